packet_filter_fifo: RTL and testbench
=====================================

// Module: packet_filter_fifo
// PURPOSE
// Parametrised successor of the local-port packet filter for the Hermes NoC. Sits between an untrusted
// injector and a router local port. Validates ADDR and SIZE header checksums and buffers the validated
// header internally; header flits are forwarded only after SIZE validates. On sender stall it pads the
// packet tail with zero flits. Adds flit-width/depth generality, a MaxSize bound and drop/pad statistics.
// PARAMETERS
// FlitWidth   32   flit width W (even, >=16); H = W/2 is the half-flit width
// XMax        8'd3 router X coordinate, key byte 1
// YMax        8'd3 router Y coordinate, key byte 0
// Depth       4    output FIFO entries (power of 2, >=2)
// TimeoutMax  10   idle cycles tolerated inside a packet before abort/pad (>=2)
// MaxSize     256  largest legal payload length; SIZE=0 or >MaxSize is dropped
// PORTS
// clk        in   1  clock, rising edge
// reset      in   1  synchronous, active-high
// rx         in   1  input flit valid
// data_in    in   W  input flit
// credit_o   out  1  filter accepts data_in this cycle; transfer = rx && credit_o
// tx         out  1  output flit valid (FIFO not empty)
// data_out   out  W  FIFO head flit
// credit_i   in   1  router accepts; pop = tx && credit_i
// drop_count out  16 saturating count of discarded headers (bad SIZE, bad length, SIZE timeout)
// pad_count  out  16 saturating count of packets completed by padding
// BEHAVIOUR
// - Key K = {XMax,YMax} zero-extended to H. ADDR valid iff hi(f)==lo(f)^K. SIZE valid iff
//   hi(s)==lo(s)^hi(addr) and 1<=lo(s)<=MaxSize.
// - Reset: state S_ADDR, FIFO empty, tx=0, data_out=0, counters 0, credit_o=1, timer=TimeoutMax.
// - S_ADDR: credit_o=1. Accepted flit failing ADDR check is silently discarded (not counted). Passing
//   flit is latched in addr_q -> S_SIZE; timer reloads.
// - S_SIZE: credit_o=1. Accepted flit passing SIZE check -> latched in size_q, remaining=lo(s),
//   -> S_HDR_A; failing -> drop_count++, -> S_ADDR. Timer expiry -> drop_count++, -> S_ADDR.
// - S_HDR_A / S_HDR_S: credit_o=0; push addr_q then size_q, one per cycle, each only when FIFO not full
//   (hold otherwise); after size_q push -> S_PAYLOAD, timer reloads.
// - S_PAYLOAD: credit_o = FIFO not full (may include same-cycle pop). Each accepted flit pushed
//   unmodified, remaining--; the push of the last flit (remaining==1) -> S_ADDR. Timer expiry ->
//   pad_count++, -> S_PAD.
// - S_PAD: credit_o=0; push all-zero flit each cycle FIFO not full, remaining--; last -> S_ADDR.
// - Timer: active in S_SIZE/S_PAYLOAD only; reloads on every accepted flit; decrements otherwise;
//   expiry at the cycle count reaches 0, i.e. TimeoutMax consecutive non-accepting cycles. Stalls
//   caused by credit_o=0 (FIFO full) do not decrement the timer.
// - Latency: payload flit accepted in cycle n is visible on data_out no earlier than n+1. Header emission
//   adds 2 cycles.
// - FIFO full + credit_i same cycle: push and pop both occur; empty FIFO never bypasses.
// - Counters saturate at 16'hFFFF. Reset mid-packet discards FIFO contents and returns to S_ADDR.
// - Widths: remaining is H bits; all checksum math is H-bit XOR; no carries.
// STRUCTURE
// - packet_filter_pkg: state_t enum {S_ADDR,S_SIZE,S_HDR_A,S_HDR_S,S_PAYLOAD,S_PAD}; functions
//   addr_ok(flit,key) and size_ok(flit,addr_hi,max) parametrised via W.
// - One sub-module pf_sync_fifo (W x Depth, push/pop/full/empty, sync reset); FSM, timer and counters
//   live in the top.
// TESTING (W=32, XMax=YMax=3, K=0x0303, Depth=4, TimeoutMax=10, MaxSize=256)
// 1 Good packet 0x0202_0101, 0x0201_0003, P1,P2,P3, credit_i=1 -> data_out shows same 5 flits in order; counters 0.
// 2 Bad ADDR 0x1234_0101 then packet of test 1 -> only test-1 flits emitted; drop_count=0.
// 3 ADDR ok, SIZE 0x0000_0003 (bad check) -> nothing emitted, drop_count=1, next good packet passes.
// 4 SIZE lo=0x0200 (512>MaxSize, checksum correct) -> dropped, drop_count=1, no tx.
// 5 SIZE=3, only P1 sent then rx=0 for 10 cycles -> ADDR,SIZE,P1,0,0 emitted; pad_count=1; credit_o=0 during pad.
// 6 credit_i=0 for 20 cycles during payload -> FIFO fills, credit_o=0, no timeout, no flit lost; reset asserted mid-packet -> tx=0 next cycle.

Source files
------------

// File: rtl/packet_filter_pkg.sv
// Shared types and header checksum helpers for the NoC local-port packet filter.
// Flits are widened to FLIT_MAX bits so one function body serves any even flit width.
package packet_filter_pkg;

  localparam int FLIT_MAX = 128;

  typedef logic [FLIT_MAX-1:0] flit_t;

  typedef enum logic [2:0] {
    S_ADDR,
    S_SIZE,
    S_HDR_A,
    S_HDR_S,
    S_PAYLOAD,
    S_PAD
  } state_t;

  function automatic flit_t half_mask(int unsigned w);
    return (flit_t'(1) << (w / 2)) - flit_t'(1);
  endfunction

  // ADDR flit is genuine when its high half equals its low half XOR the router key.
  function automatic logic addr_ok(flit_t flit, int unsigned w, flit_t key);
    flit_t m  = half_mask(w);
    flit_t lo = flit & m;
    flit_t hi = (flit >> (w / 2)) & m;
    return hi == (lo ^ (key & m));
  endfunction

  // SIZE flit is chained to the ADDR high half and must carry a usable length.
  function automatic logic size_ok(flit_t flit, int unsigned w, flit_t addr_hi, int unsigned max);
    flit_t m  = half_mask(w);
    flit_t lo = flit & m;
    flit_t hi = (flit >> (w / 2)) & m;
    return (hi == (lo ^ (addr_hi & m))) && (lo != '0) && (lo <= flit_t'(max));
  endfunction

endpackage

// File: rtl/packet_filter_if.sv
// Flit handshake bundle between injector, filter and router local port.
// The slave modport is the filter's view; master is the surrounding environment.
interface packet_filter_if #(
  parameter int FlitWidth = 32
);

  logic                 rx;
  logic [FlitWidth-1:0] data_in;
  logic                 credit_o;
  logic                 tx;
  logic [FlitWidth-1:0] data_out;
  logic                 credit_i;

  modport slave (
    input  rx,
    input  data_in,
    input  credit_i,
    output credit_o,
    output tx,
    output data_out
  );

  modport master (
    output rx,
    output data_in,
    output credit_i,
    input  credit_o,
    input  tx,
    input  data_out
  );

endinterface

// File: rtl/pf_sync_fifo.sv
// Synchronous FIFO for validated flits; head reads as zero while empty.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module pf_sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/packet_filter_fifo.sv
// Local-port packet filter: checks ADDR/SIZE header checksums, forwards validated
// packets through an output FIFO and pads packets whose sender goes quiet.
module packet_filter_fifo
  import packet_filter_pkg::*;
#(
  parameter int       FlitWidth  = 32,
  parameter logic [7:0] XMax     = 8'd3,
  parameter logic [7:0] YMax     = 8'd3,
  parameter int       Depth      = 4,
  parameter int       TimeoutMax = 10,
  parameter int       MaxSize    = 256
) (
  input  logic               clk,
  input  logic               reset,
  packet_filter_if.slave     bus,
  output logic [15:0]        drop_count,
  output logic [15:0]        pad_count
);

  localparam int    H   = FlitWidth / 2;
  localparam int    TW  = $clog2(TimeoutMax + 1);
  localparam flit_t KEY = flit_t'({XMax, YMax});

  state_t               state;
  state_t               state_nxt;
  logic [FlitWidth-1:0] addr_q;
  logic [FlitWidth-1:0] size_q;
  logic [H-1:0]         remaining;
  logic [TW-1:0]        timer;

  logic                 credit;
  logic                 accept;
  logic                 timer_active;
  logic                 expire;
  logic                 push;
  logic [FlitWidth-1:0] push_data;
  logic                 load_addr;
  logic                 load_size;
  logic                 dec_rem;
  logic                 drop_inc;
  logic                 pad_inc;
  logic                 full;
  logic                 empty;
  logic [FlitWidth-1:0] fifo_dout;

  assign credit = (state == S_ADDR) || (state == S_SIZE) ||
                  ((state == S_PAYLOAD) && (!full || bus.credit_i));
  assign accept       = bus.rx && credit;
  assign timer_active = (state == S_SIZE) || (state == S_PAYLOAD);
  // A backpressure stall (credit low) never counts toward the timeout.
  assign expire = timer_active && !accept && credit && (timer == TW'(1));

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = bus.data_in;
    load_addr = 1'b0;
    load_size = 1'b0;
    dec_rem   = 1'b0;
    drop_inc  = 1'b0;
    pad_inc   = 1'b0;
    case (state)
      S_ADDR: begin
        if (accept && addr_ok(flit_t'(bus.data_in), FlitWidth, KEY)) begin
          load_addr = 1'b1;
          state_nxt = S_SIZE;
        end
      end
      S_SIZE: begin
        if (accept) begin
          if (size_ok(flit_t'(bus.data_in), FlitWidth, flit_t'(addr_q[FlitWidth-1:H]), MaxSize)) begin
            load_size = 1'b1;
            state_nxt = S_HDR_A;
          end else begin
            drop_inc  = 1'b1;
            state_nxt = S_ADDR;
          end
        end else if (expire) begin
          drop_inc  = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_HDR_A: begin
        if (!full) begin
          push      = 1'b1;
          push_data = addr_q;
          state_nxt = S_HDR_S;
        end
      end
      S_HDR_S: begin
        if (!full) begin
          push      = 1'b1;
          push_data = size_q;
          state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          push    = 1'b1;
          dec_rem = 1'b1;
          if (remaining == H'(1)) state_nxt = S_ADDR;
        end else if (expire) begin
          pad_inc   = 1'b1;
          state_nxt = S_PAD;
        end
      end
      S_PAD: begin
        if (!full) begin
          push      = 1'b1;
          push_data = '0;
          dec_rem   = 1'b1;
          if (remaining == H'(1)) state_nxt = S_ADDR;
        end
      end
      default: state_nxt = S_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_ADDR;
      remaining  <= '0;
      timer      <= TW'(TimeoutMax);
      drop_count <= '0;
      pad_count  <= '0;
    end else begin
      state <= state_nxt;
      if (load_size)    remaining <= bus.data_in[H-1:0];
      else if (dec_rem) remaining <= remaining - H'(1);
      if (!timer_active || accept) timer <= TW'(TimeoutMax);
      else if (credit)             timer <= timer - TW'(1);
      if (drop_inc && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (pad_inc && (pad_count != 16'hFFFF))   pad_count  <= pad_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_addr) addr_q <= bus.data_in;
    if (load_size) size_q <= bus.data_in;
  end

  pf_sync_fifo #(
    .Width (FlitWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (bus.credit_i),
    .din   (push_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign bus.credit_o = credit;
  assign bus.tx       = !empty;
  assign bus.data_out = fifo_dout;

endmodule

// File: tb/tb_packet_filter_fifo.sv
// Directed bench for packet_filter_fifo: header validation, drops, padding,
// backpressure and mid-packet reset with hand-computed flit streams.
module tb_packet_filter_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] drop_count;
  logic [15:0] pad_count;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] got [$];
  logic [31:0] good_pkt [5] = '{32'h0202_0101, 32'h0201_0003, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};

  packet_filter_if #(.FlitWidth(32)) bus ();

  packet_filter_fifo #(
    .FlitWidth  (32),
    .XMax       (8'd3),
    .YMax       (8'd3),
    .Depth      (4),
    .TimeoutMax (10),
    .MaxSize    (256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .drop_count (drop_count),
    .pad_count  (pad_count)
  );

  always #5 clk = ~clk;

  // Record every flit the router side actually takes.
  always @(negedge clk) begin
    if (!reset && bus.tx && bus.credit_i) got.push_back(bus.data_out);
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset        = 1'b1;
    bus.rx       = 1'b0;
    bus.data_in  = '0;
    bus.credit_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    got.delete();
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] f);
    bit done = 1'b0;
    bus.rx      = 1'b1;
    bus.data_in = f;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.credit_o) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rx = 1'b0;
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL send_accept flit=%h accepted=0 required=1", f);
    end
  endtask

  task automatic send_good();
    foreach (good_pkt[i]) send(good_pkt[i]);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    compared++; if (bus.tx !== 1'b0) begin mismatched++; $display("FAIL reset_tx got=%b exp=0", bus.tx); end
    compared++; if (bus.data_out !== 32'h0) begin mismatched++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out); end
    compared++; if (bus.credit_o !== 1'b1) begin mismatched++; $display("FAIL reset_credit_o got=%b exp=1", bus.credit_o); end
    compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    compared++; if (pad_count !== 16'd0) begin mismatched++; $display("FAIL reset_pad got=%0d exp=0", pad_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_good_packet();
    do_reset();
    send_good();
    idle(12);
    compared++;
    if (got.size() != 5) begin mismatched++; $display("FAIL good_len got=%0d exp=5", got.size()); end
    foreach (good_pkt[i]) begin
      logic [31:0] act;
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      compared++;
      if (act !== good_pkt[i]) begin mismatched++; $display("FAIL good_flit%0d got=%h exp=%h", i, act, good_pkt[i]); end
    end
    compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL good_drop got=%0d exp=0", drop_count); end
    compared++; if (pad_count !== 16'd0) begin mismatched++; $display("FAIL good_pad got=%0d exp=0", pad_count); end
  endtask

  task automatic test_bad_addr();
    do_reset();
    send(32'h1234_0101);
    send_good();
    idle(12);
    compared++;
    if (got.size() != 5) begin mismatched++; $display("FAIL badaddr_len got=%0d exp=5", got.size()); end
    foreach (good_pkt[i]) begin
      logic [31:0] act;
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      compared++;
      if (act !== good_pkt[i]) begin mismatched++; $display("FAIL badaddr_flit%0d got=%h exp=%h", i, act, good_pkt[i]); end
    end
    compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL badaddr_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_bad_size();
    do_reset();
    send(32'h0202_0101);
    send(32'h0000_0003);
    idle(2);
    compared++; if (drop_count !== 16'd1) begin mismatched++; $display("FAIL badsize_drop got=%0d exp=1", drop_count); end
    compared++; if (got.size() != 0) begin mismatched++; $display("FAIL badsize_tx got=%0d flits exp=0", got.size()); end
    send_good();
    idle(12);
    compared++;
    if (got.size() != 5) begin mismatched++; $display("FAIL badsize_next_len got=%0d exp=5", got.size()); end
    foreach (good_pkt[i]) begin
      logic [31:0] act;
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      compared++;
      if (act !== good_pkt[i]) begin mismatched++; $display("FAIL badsize_flit%0d got=%h exp=%h", i, act, good_pkt[i]); end
    end
  endtask

  task automatic test_size_limits();
    do_reset();
    // Length 512 with a correct checksum, then length 0 with a correct checksum.
    send(32'h0202_0101);
    send(32'h0002_0200);
    idle(2);
    compared++; if (drop_count !== 16'd1) begin mismatched++; $display("FAIL oversize_drop got=%0d exp=1", drop_count); end
    send(32'h0202_0101);
    send(32'h0202_0000);
    idle(12);
    compared++; if (drop_count !== 16'd2) begin mismatched++; $display("FAIL zerosize_drop got=%0d exp=2", drop_count); end
    compared++; if (got.size() != 0) begin mismatched++; $display("FAIL limits_tx got=%0d flits exp=0", got.size()); end
    compared++; if (bus.tx !== 1'b0) begin mismatched++; $display("FAIL limits_tx_flag got=%b exp=0", bus.tx); end
  endtask

  task automatic test_size_timeout();
    do_reset();
    send(32'h0202_0101);
    idle(9);
    compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL sizeto_early got=%0d exp=0", drop_count); end
    idle(1);
    compared++; if (drop_count !== 16'd1) begin mismatched++; $display("FAIL sizeto_drop got=%0d exp=1", drop_count); end
    idle(10);
    compared++; if (got.size() != 0) begin mismatched++; $display("FAIL sizeto_tx got=%0d flits exp=0", got.size()); end
  endtask

  task automatic test_pad();
    logic [31:0] exp [$];
    exp = '{32'h0202_0101, 32'h0201_0003, 32'hA000_0001, 32'h0, 32'h0};
    do_reset();
    send(32'h0202_0101);
    send(32'h0201_0003);
    send(32'hA000_0001);
    idle(9);
    compared++; if (pad_count !== 16'd0) begin mismatched++; $display("FAIL pad_early got=%0d exp=0", pad_count); end
    idle(1);
    @(negedge clk);
    compared++; if (pad_count !== 16'd1) begin mismatched++; $display("FAIL pad_count got=%0d exp=1", pad_count); end
    compared++; if (bus.credit_o !== 1'b0) begin mismatched++; $display("FAIL pad_credit got=%b exp=0", bus.credit_o); end
    @(posedge clk); #1;
    idle(12);
    compared++;
    if (got.size() != exp.size()) begin mismatched++; $display("FAIL pad_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      logic [31:0] act;
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      compared++;
      if (act !== exp[i]) begin mismatched++; $display("FAIL pad_flit%0d got=%h exp=%h", i, act, exp[i]); end
    end
    compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL pad_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.credit_i = 1'b0;
    send(good_pkt[0]);
    send(good_pkt[1]);
    send(good_pkt[2]);
    send(good_pkt[3]);
    bus.rx      = 1'b1;
    bus.data_in = good_pkt[4];
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    compared++; if (bus.credit_o !== 1'b0) begin mismatched++; $display("FAIL bp_credit got=%b exp=0", bus.credit_o); end
    compared++; if (bus.tx !== 1'b1) begin mismatched++; $display("FAIL bp_tx got=%b exp=1", bus.tx); end
    compared++; if (bus.data_out !== good_pkt[0]) begin mismatched++; $display("FAIL bp_head got=%h exp=%h", bus.data_out, good_pkt[0]); end
    compared++; if (pad_count !== 16'd0) begin mismatched++; $display("FAIL bp_pad got=%0d exp=0", pad_count); end
    @(posedge clk); #1;
    bus.credit_i = 1'b1;
    send(good_pkt[4]);
    idle(12);
    compared++;
    if (got.size() != 5) begin mismatched++; $display("FAIL bp_len got=%0d exp=5", got.size()); end
    foreach (good_pkt[i]) begin
      logic [31:0] act;
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      compared++;
      if (act !== good_pkt[i]) begin mismatched++; $display("FAIL bp_flit%0d got=%h exp=%h", i, act, good_pkt[i]); end
    end
    compared++; if (pad_count !== 16'd0) begin mismatched++; $display("FAIL bp_pad_end got=%0d exp=0", pad_count); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bus.credit_i = 1'b0;
    send(good_pkt[0]);
    send(good_pkt[1]);
    send(good_pkt[2]);
    idle(1);
    @(negedge clk);
    compared++; if (bus.tx !== 1'b1) begin mismatched++; $display("FAIL midrst_pre_tx got=%b exp=1", bus.tx); end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    compared++; if (bus.tx !== 1'b0) begin mismatched++; $display("FAIL midrst_tx got=%b exp=0", bus.tx); end
    compared++; if (bus.credit_o !== 1'b1) begin mismatched++; $display("FAIL midrst_credit got=%b exp=1", bus.credit_o); end
    compared++; if (bus.data_out !== 32'h0) begin mismatched++; $display("FAIL midrst_data got=%h exp=0", bus.data_out); end
    @(posedge clk); #1;
    got.delete();
    bus.credit_i = 1'b1;
    send_good();
    idle(12);
    compared++;
    if (got.size() != 5) begin mismatched++; $display("FAIL midrst_len got=%0d exp=5", got.size()); end
    foreach (good_pkt[i]) begin
      logic [31:0] act;
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      compared++;
      if (act !== good_pkt[i]) begin mismatched++; $display("FAIL midrst_flit%0d got=%h exp=%h", i, act, good_pkt[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [$];
    do_reset();
    send_good();
    // Minimum-length packet: SIZE=1, checksum 0x0001^0x0202.
    send(32'h0202_0101);
    send(32'h0203_0001);
    send(32'hB000_0001);
    send_good();
    idle(14);
    foreach (good_pkt[i]) exp.push_back(good_pkt[i]);
    exp.push_back(32'h0202_0101);
    exp.push_back(32'h0203_0001);
    exp.push_back(32'hB000_0001);
    foreach (good_pkt[i]) exp.push_back(good_pkt[i]);
    compared++;
    if (got.size() != exp.size()) begin mismatched++; $display("FAIL b2b_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      logic [31:0] act;
      act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      compared++;
      if (act !== exp[i]) begin mismatched++; $display("FAIL b2b_flit%0d got=%h exp=%h", i, act, exp[i]); end
    end
    compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL b2b_drop got=%0d exp=0", drop_count); end
  endtask

  initial begin
    bus.rx       = 1'b0;
    bus.data_in  = '0;
    bus.credit_i = 1'b1;
    test_reset();
    test_good_packet();
    test_bad_addr();
    test_bad_size();
    test_size_limits();
    test_size_timeout();
    test_pad();
    test_backpressure();
    test_reset_mid_packet();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
